// File: rtl/sap_pkg.sv
// Shared SAP-1 definitions: address width and the holding-slot state encoding.
package sap_pkg;

    localparam int unsigned ADDR_W = 4;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/demux_slot.sv
// One-entry holding slot with valid/ack handshake; the word is stable while FULL.
module demux_slot
    import sap_pkg::*;
#(
    parameter int unsigned WIDTH = ADDR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             ack,
    output logic [WIDTH-1:0] dout,
    output logic             valid
);

    slot_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        unique case (state_q)
            SLOT_EMPTY: begin
                if (push) begin
                    state_d = SLOT_FULL;
                    data_d  = din;
                end
            end
            SLOT_FULL: begin
                // A push in the ack cycle refills without a bubble.
                if (push) begin
                    data_d = din;
                end else if (ack) begin
                    state_d = SLOT_EMPTY;
                end
            end
            default: state_d = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign dout  = data_q;
    assign valid = (state_q == SLOT_FULL);

endmodule

// File: rtl/demux2_4.sv
// Registered 1:2 address demultiplexer: routes address_in to one of two holding slots.
module demux2_4
    import sap_pkg::*;
#(
    parameter int unsigned WIDTH = ADDR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] address_in,
    input  logic             select,
    input  logic             load,
    output logic             ready,
    output logic [WIDTH-1:0] address_1,
    output logic             valid_1,
    input  logic             ack_1,
    output logic [WIDTH-1:0] address_2,
    output logic             valid_2,
    input  logic             ack_2
);

    logic push_1;
    logic push_2;

    // ready depends only on the addressed slot, never on load.
    always_comb begin
        ready  = select ? (~valid_2 | ack_2) : (~valid_1 | ack_1);
        push_1 = load & ready & ~select;
        push_2 = load & ready & select;
    end

    demux_slot #(.WIDTH(WIDTH)) u_slot_1 (
        .clk   (clk),
        .reset (reset),
        .push  (push_1),
        .din   (address_in),
        .ack   (ack_1),
        .dout  (address_1),
        .valid (valid_1)
    );

    demux_slot #(.WIDTH(WIDTH)) u_slot_2 (
        .clk   (clk),
        .reset (reset),
        .push  (push_2),
        .din   (address_in),
        .ack   (ack_2),
        .dout  (address_2),
        .valid (valid_2)
    );

endmodule
